// File: rtl/io_device_decoder.sv
// -----------------------------------------------------------------------------
// io_device_decoder
//
// Purpose
//   Sits directly downstream of the I/O bridge master port. One 64-bit
//   Wishbone-style request at a time is decoded from the 4-bit device index
//   field of the address (s_adr_i[DEV_ADR_LSB +: 4]). It is registered toward
//   the selected device, and that device's ack and read data are returned to
//   the bridge. Each device access is bounded by a timeout counter, so a
//   silent device or an unmapped index always produces a response and never
//   hangs the bridge.
//
// Configuration macro
//   IO_BUS_ERR_EN  defined   : unmapped index or timeout answers with s_err_o=1
//                              and s_ack_o=0
//                  undefined : s_err_o is tied 0. Unmapped index or timeout
//                              answers with s_ack_o=1 and all-ones data.
//
// Handshake
//   Bridge side: a request is taken when s_cyc_i & s_stb_i are high and no
//   response is pending. The response (s_ack_o or s_err_o) is a level that
//   stays high until the bridge drops s_stb_i. The bridge must hold the
//   request fields stable while s_stb_i is high.
//   Device side: d_cyc_o/d_stb_o/d_cs_o and the request fields are registered
//   and stay stable until the selected device raises its d_ack_i bit. That bit
//   is sampled on a rising edge, and the access ends on that edge.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   s_cyc_i .. s_dat_i     request from the bridge
//   s_ack_o, s_err_o,      response to the bridge
//   s_dat_o
//   d_cs_o                 one-hot device select (zero when idle)
//   d_cyc_o .. d_dat_o     registered request toward the devices
//   d_ack_i, d_dat_i       per-device ack and read data (device k uses
//                          d_dat_i[64k +: 64])
//   dbg_state_o            current FSM state, for observation only
// -----------------------------------------------------------------------------
module io_device_decoder #(
   parameter int NDEV        = 8,
   parameter int DEV_ADR_LSB = 16,
   parameter int TIMEOUT     = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 s_cyc_i,
   input  logic                 s_stb_i,
   input  logic                 s_we_i,
   input  logic [7:0]           s_sel_i,
   input  logic [31:0]          s_adr_i,
   input  logic [63:0]          s_dat_i,
   output logic                 s_ack_o,
   output logic                 s_err_o,
   output logic [63:0]          s_dat_o,
   output logic [NDEV-1:0]      d_cs_o,
   output logic                 d_cyc_o,
   output logic                 d_stb_o,
   output logic                 d_we_o,
   output logic [7:0]           d_sel_o,
   output logic [31:0]          d_adr_o,
   output logic [63:0]          d_dat_o,
   input  logic [NDEV-1:0]      d_ack_i,
   input  logic [NDEV*64-1:0]   d_dat_i,
   output logic [1:0]           dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_FAULT  = 2'd2,
      S_HOLD   = 2'd3
   } state_e;

   localparam logic [4:0]  NDEV_L     = 5'(NDEV);
   localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [15:0]       timer_q, timer_d;
   logic [3:0]        idx_q, idx_d;
   logic              s_ack_q, s_ack_d;
   logic [63:0]       s_dat_q, s_dat_d;
   logic [NDEV-1:0]   d_cs_q, d_cs_d;
   logic              d_cyc_q, d_cyc_d;
   logic              d_stb_q, d_stb_d;
   logic              d_we_q, d_we_d;
   logic [7:0]        d_sel_q, d_sel_d;
   logic [31:0]       d_adr_q, d_adr_d;
   logic [63:0]       d_dat_q, d_dat_d;
`ifdef IO_BUS_ERR_EN
   logic              s_err_q, s_err_d;
`endif

   // Request decode
   logic [3:0]        req_idx;
   logic              req_mapped;
   logic [NDEV-1:0]   req_cs;
   logic              req_valid;

   assign req_idx    = s_adr_i[DEV_ADR_LSB +: 4];
   assign req_mapped = ({1'b0, req_idx} < NDEV_L);
   // A pending response blocks acceptance, so a request is never taken in
   // the same cycle that a response is still being held.
   assign req_valid  = s_cyc_i & s_stb_i & ~s_ack_o & ~s_err_o;

   always_comb begin
      req_cs = '0;
      for (int k = 0; k < NDEV; k++) begin
         req_cs[k] = (req_idx == 4'(k));
      end
   end

   // Only the selected device's ack and data are observed. Acks from any
   // other device are ignored, even in the same cycle.
   logic        sel_ack;
   logic [63:0] sel_dat;

   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      for (int k = 0; k < NDEV; k++) begin
         if (idx_q == 4'(k)) begin
            sel_ack = d_ack_i[k];
            sel_dat = d_dat_i[64*k +: 64];
         end
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      s_ack_d = s_ack_q;
      s_dat_d = s_dat_q;
      d_cs_d  = d_cs_q;
      d_cyc_d = d_cyc_q;
      d_stb_d = d_stb_q;
      d_we_d  = d_we_q;
      d_sel_d = d_sel_q;
      d_adr_d = d_adr_q;
      d_dat_d = d_dat_q;
`ifdef IO_BUS_ERR_EN
      s_err_d = s_err_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               idx_d = req_idx;
               if (req_mapped) begin
                  d_cs_d  = req_cs;
                  d_cyc_d = 1'b1;
                  d_stb_d = 1'b1;
                  d_we_d  = s_we_i;
                  d_sel_d = s_sel_i;
                  d_adr_d = s_adr_i;
                  d_dat_d = s_dat_i;
                  timer_d = '0;
                  state_d = S_ACTIVE;
               end else begin
                  state_d = S_FAULT;
               end
            end
         end

         S_ACTIVE: begin
            // Priority: selected ack, then bridge abort, then timeout.
            // A same-cycle ack still completes an aborted access, and an
            // abort beats a timeout that expires in the same cycle.
            if (sel_ack) begin
               s_dat_d = sel_dat;
               s_ack_d = 1'b1;
               d_cs_d  = '0;
               d_cyc_d = 1'b0;
               d_stb_d = 1'b0;
               d_we_d  = 1'b0;
               state_d = S_HOLD;
            end else if (!s_cyc_i) begin
               d_cs_d  = '0;
               d_cyc_d = 1'b0;
               d_stb_d = 1'b0;
               d_we_d  = 1'b0;
               d_sel_d = '0;
               d_adr_d = '0;
               d_dat_d = '0;
               state_d = S_IDLE;
            end else if (timer_q == TIMEOUT_M1) begin
               d_cs_d  = '0;
               d_cyc_d = 1'b0;
               d_stb_d = 1'b0;
               d_we_d  = 1'b0;
               d_sel_d = '0;
               d_adr_d = '0;
               d_dat_d = '0;
               state_d = S_FAULT;
            end else if (timer_q != 16'hFFFF) begin
               timer_d = timer_q + 16'd1;
            end
         end

         S_FAULT: begin
            s_dat_d = '1;
`ifdef IO_BUS_ERR_EN
            s_err_d = 1'b1;
`else
            s_ack_d = 1'b1;
`endif
            state_d = S_HOLD;
         end

         S_HOLD: begin
            if (!s_stb_i) begin
               s_ack_d = 1'b0;
`ifdef IO_BUS_ERR_EN
               s_err_d = 1'b0;
`endif
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers. Reset aborts any access without a response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         s_ack_q <= 1'b0;
         s_dat_q <= '0;
         d_cs_q  <= '0;
         d_cyc_q <= 1'b0;
         d_stb_q <= 1'b0;
         d_we_q  <= 1'b0;
         d_sel_q <= '0;
         d_adr_q <= '0;
         d_dat_q <= '0;
`ifdef IO_BUS_ERR_EN
         s_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         s_ack_q <= s_ack_d;
         s_dat_q <= s_dat_d;
         d_cs_q  <= d_cs_d;
         d_cyc_q <= d_cyc_d;
         d_stb_q <= d_stb_d;
         d_we_q  <= d_we_d;
         d_sel_q <= d_sel_d;
         d_adr_q <= d_adr_d;
         d_dat_q <= d_dat_d;
`ifdef IO_BUS_ERR_EN
         s_err_q <= s_err_d;
`endif
      end
   end

   assign s_ack_o     = s_ack_q;
   assign s_dat_o     = s_dat_q;
   assign d_cs_o      = d_cs_q;
   assign d_cyc_o     = d_cyc_q;
   assign d_stb_o     = d_stb_q;
   assign d_we_o      = d_we_q;
   assign d_sel_o     = d_sel_q;
   assign d_adr_o     = d_adr_q;
   assign d_dat_o     = d_dat_q;
   assign dbg_state_o = state_q;

`ifdef IO_BUS_ERR_EN
   assign s_err_o = s_err_q;
`else
   assign s_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_io_device_decoder.sv
// -----------------------------------------------------------------------------
// tb_io_device_decoder
//
// Purpose
//   Exercises io_device_decoder with directed and randomized transactions.
//   Expectations come from a transaction-level timing model. The model
//   resolves which event ends each access (device ack, bridge abort, timeout
//   or unmapped index) and derives the cycle windows for the strobe and the
//   response. It then checks every cycle against those windows.
// -----------------------------------------------------------------------------
module tb_io_device_decoder;

   localparam int NDEV        = 8;
   localparam int DEV_ADR_LSB = 16;
   localparam int TIMEOUT     = 255;
   localparam int NEVER       = -1;

`ifdef IO_BUS_ERR_EN
   localparam bit ERR_MODE = 1'b1;
`else
   localparam bit ERR_MODE = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic                 s_cyc_i, s_stb_i, s_we_i;
   logic [7:0]           s_sel_i;
   logic [31:0]          s_adr_i;
   logic [63:0]          s_dat_i;
   logic                 s_ack_o, s_err_o;
   logic [63:0]          s_dat_o;
   logic [NDEV-1:0]      d_cs_o;
   logic                 d_cyc_o, d_stb_o, d_we_o;
   logic [7:0]           d_sel_o;
   logic [31:0]          d_adr_o;
   logic [63:0]          d_dat_o;
   logic [NDEV-1:0]      d_ack_i;
   logic [NDEV*64-1:0]   d_dat_i;
   logic [1:0]           dbg_state_o;

   always #5 clk_i = ~clk_i;

   io_device_decoder #(
      .NDEV        (NDEV),
      .DEV_ADR_LSB (DEV_ADR_LSB),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .s_cyc_i     (s_cyc_i),
      .s_stb_i     (s_stb_i),
      .s_we_i      (s_we_i),
      .s_sel_i     (s_sel_i),
      .s_adr_i     (s_adr_i),
      .s_dat_i     (s_dat_i),
      .s_ack_o     (s_ack_o),
      .s_err_o     (s_err_o),
      .s_dat_o     (s_dat_o),
      .d_cs_o      (d_cs_o),
      .d_cyc_o     (d_cyc_o),
      .d_stb_o     (d_stb_o),
      .d_we_o      (d_we_o),
      .d_sel_o     (d_sel_o),
      .d_adr_o     (d_adr_o),
      .d_dat_o     (d_dat_o),
      .d_ack_i     (d_ack_i),
      .d_dat_i     (d_dat_i),
      .dbg_state_o (dbg_state_o)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] dev_dat [NDEV];

   task automatic check_eq(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic randomize_devs();
      for (int k = 0; k < NDEV; k++) dev_dat[k] = {$urandom, $urandom};
   endtask

   // One bridge transaction. Called and returns at a negedge.
   //   delay    : cycles between first visible d_stb_o and the device ack
   //              (NEVER = no ack)
   //   abort_at : cycle at which the bridge drops cyc/stb (0 = no abort)
   //   hold     : extra cycles the bridge keeps stb high after the response
   task automatic run_txn(input string name, input logic [31:0] adr,
                          input logic we, input logic [7:0] sel,
                          input logic [63:0] dat, input int delay,
                          input int abort_at, input int hold);
      int              idx, p_ack, p_abort, p_to, resp, stb_last, drop, last;
      int              resp_end;
      bit              mapped, has_resp, fault, exp_stb, exp_resp, exp_ack, exp_err;
      logic [NDEV-1:0] cs_exp;
      logic [63:0]     exp_dat;
      int              inf;

      inf    = 1 << 30;
      idx    = int'(adr[DEV_ADR_LSB +: 4]);
      mapped = (idx < NDEV);
      for (int k = 0; k < NDEV; k++) d_dat_i[64*k +: 64] = dev_dat[k];
      cs_exp = '0;
      if (mapped) cs_exp[idx] = 1'b1;

      // Resolve which event ends the access. Cycle c is the negedge c cycles
      // after the request was driven. Event p_x is the posedge sampled
      // before cycle p_x.
      p_ack    = (delay >= 0) ? 2 + delay : inf;
      p_abort  = (abort_at > 0) ? abort_at + 1 : inf;
      p_to     = TIMEOUT + 1;
      has_resp = 1'b1;
      fault    = 1'b0;
      resp     = 0;
      stb_last = 0;
      if (!mapped) begin
         fault = 1'b1;
         resp  = 2;
      end else if (p_ack <= p_abort && p_ack <= p_to) begin
         resp     = p_ack;
         stb_last = p_ack - 1;
      end else if (p_abort <= p_to) begin
         has_resp = 1'b0;
         stb_last = p_abort - 1;
      end else begin
         fault    = 1'b1;
         resp     = TIMEOUT + 2;
         stb_last = TIMEOUT;
      end
      drop     = (abort_at > 0) ? abort_at : resp + hold;
      resp_end = (resp > drop) ? resp : drop;
      last     = has_resp ? resp_end + 1 : p_abort;

      if (has_resp) begin
         if (fault) exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
         else       exp_q.push_back(dev_dat[idx]);
      end

      s_cyc_i = 1'b1;
      s_stb_i = 1'b1;
      s_we_i  = we;
      s_sel_i = sel;
      s_adr_i = adr;
      s_dat_i = dat;
      d_ack_i = '0;

      for (int c = 1; c <= last; c++) begin
         @(negedge clk_i);
         exp_stb  = mapped && (c <= stb_last);
         exp_resp = has_resp && (c >= resp) && (c <= resp_end);
         exp_err  = exp_resp && fault && ERR_MODE;
         exp_ack  = exp_resp && !(fault && ERR_MODE);
         check_eq({name, ":status"}, {s_ack_o, s_err_o, d_cyc_o, d_stb_o},
                  {exp_ack, exp_err, exp_stb, exp_stb});
         if (exp_stb) begin
            check_eq({name, ":cs"}, d_cs_o, cs_exp);
            check_eq({name, ":dreq"}, {d_we_o, d_sel_o, d_adr_o, d_dat_o},
                     {we, sel, adr, dat});
         end else begin
            check_eq({name, ":cs_idle"}, d_cs_o, '0);
         end
         if (has_resp && c == resp) begin
            exp_dat = exp_q.pop_front();
            check_eq({name, ":rdata"}, s_dat_o, exp_dat);
         end
         // drive the next cycle: bridge drop, unselected noise acks, device ack
         if (c >= drop) begin
            s_cyc_i = 1'b0;
            s_stb_i = 1'b0;
         end
         d_ack_i = NDEV'($urandom) & ~cs_exp;
         if (mapped && delay >= 0 && c == 1 + delay) d_ack_i[idx] = 1'b1;
      end
      d_ack_i = '0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #900_000;
      $display("FAIL watchdog: got no end of run, required end before 90000 cycles");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] adr;
      int          kind, idx, dly, ab;

      rst_ni  = 1'b0;
      s_cyc_i = 1'b0;
      s_stb_i = 1'b0;
      s_we_i  = 1'b0;
      s_sel_i = '0;
      s_adr_i = '0;
      s_dat_i = '0;
      d_ack_i = '0;
      d_dat_i = '0;

      repeat (3) @(negedge clk_i);
      check_eq("reset_s", {s_ack_o, s_err_o, s_dat_o}, '0);
      check_eq("reset_d", {d_cs_o, d_cyc_o, d_stb_o, d_we_o, d_sel_o, d_adr_o}, '0);
      check_eq("reset_ddat", d_dat_o, '0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // directed: read dev 2, ack 3 cycles after strobe
      randomize_devs();
      dev_dat[2] = 64'h1122_3344_5566_7788;
      run_txn("rd_dev2", 32'hFFD2_0010, 1'b0, 8'hFF, 64'h0, 3, 0, 3);
      // directed: write dev 0
      randomize_devs();
      run_txn("wr_dev0", 32'h0000_0100, 1'b1, 8'h0F, 64'hDEAD_BEEF, 1, 0, 1);
      // directed: no ack, full timeout
      randomize_devs();
      run_txn("timeout", 32'h0005_0040, 1'b0, 8'hFF, 64'h0, NEVER, 0, 2);
      // directed: unmapped index 9
      randomize_devs();
      run_txn("unmapped", 32'h0009_0000, 1'b0, 8'hFF, 64'h0, NEVER, 0, 1);
      // directed: abort two cycles into ACTIVE, then a normal access
      randomize_devs();
      run_txn("abort", 32'h0003_0008, 1'b0, 8'hFF, 64'h0, NEVER, 2, 0);
      randomize_devs();
      run_txn("after_abort", 32'h0003_0008, 1'b0, 8'hFF, 64'h0, 0, 0, 0);
      // directed boundaries: ack on the timeout cycle, abort on the timeout
      // cycle, ack together with abort
      randomize_devs();
      run_txn("ack_at_to", 32'h0007_0000, 1'b0, 8'hFF, 64'h0, TIMEOUT - 1, 0, 0);
      randomize_devs();
      run_txn("abort_at_to", 32'h0006_0000, 1'b1, 8'h3C, 64'h55, NEVER, TIMEOUT, 0);
      randomize_devs();
      run_txn("ack_abort", 32'h0001_0000, 1'b0, 8'hFF, 64'h0, 2, 3, 0);

      // directed: reset pulse in mid-access
      s_cyc_i = 1'b1;
      s_stb_i = 1'b1;
      s_we_i  = 1'b1;
      s_sel_i = 8'hFF;
      s_adr_i = 32'h0004_0000;
      s_dat_i = 64'hCAFE;
      repeat (3) @(negedge clk_i);
      check_eq("rst_pre_stb", d_stb_o, 1'b1);
      #2 rst_ni = 1'b0;
      #1;
      check_eq("rst_async_s", {s_ack_o, s_err_o, s_dat_o}, '0);
      check_eq("rst_async_d", {d_cs_o, d_cyc_o, d_stb_o, d_we_o, d_sel_o, d_adr_o}, '0);
      check_eq("rst_async_ddat", d_dat_o, '0);
      s_cyc_i = 1'b0;
      s_stb_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      randomize_devs();
      run_txn("after_rst", 32'h0004_0000, 1'b0, 8'hFF, 64'h0, 2, 0, 1);

      // randomized transactions
      for (int t = 0; t < 40; t++) begin
         randomize_devs();
         kind = $urandom_range(0, 9);
         idx  = $urandom_range(0, NDEV - 1);
         dly  = $urandom_range(0, 8);
         ab   = 0;
         if (kind == 6) dly = NEVER;
         if (kind == 7) idx = $urandom_range(NDEV, 15);
         if (kind == 8) begin
            dly = NEVER;
            ab  = $urandom_range(1, 6);
         end
         adr = $urandom;
         adr[DEV_ADR_LSB +: 4] = 4'(idx);
         run_txn("rand", adr, 1'($urandom), 8'($urandom), {$urandom, $urandom},
                 dly, ab, $urandom_range(0, 3));
      end

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
